// File: rtl/eth_rx_frame_ctrl.sv
// rtl/eth_rx_frame_ctrl.sv - Ethernet receive framer: preamble/SFD strip, length checks, byte stream out
// One-byte hold register delays each byte so the final byte can carry tlast when dv falls.
module eth_rx_frame_ctrl #(
  parameter int MIN_PRE = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_dv_in,
  input  logic        rx_er_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic [7:0]  m_tdata_out,
  output logic        m_tvalid_out,
  output logic        m_tlast_out,
  output logic        m_tuser_out,
  output logic [15:0] frame_count_out,
  output logic [15:0] err_count_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [3:0]  PRE_NEED = 4'(MIN_PRE);
  localparam logic [10:0] LEN_MIN  = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);

  state_t      state, state_nxt;
  logic [3:0]  pre_cnt, pre_cnt_nxt;
  logic [10:0] len, len_nxt;
  logic [7:0]  hold, hold_nxt;
  logic        er_flag, er_flag_nxt;
  logic [7:0]  tdata_nxt;
  logic        tvalid_nxt, tlast_nxt, tuser_nxt;
  logic        good_inc, bad_inc;

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    len_nxt     = len;
    hold_nxt    = hold;
    er_flag_nxt = er_flag;
    tdata_nxt   = 8'h00;
    tvalid_nxt  = 1'b0;
    tlast_nxt   = 1'b0;
    tuser_nxt   = 1'b0;
    good_inc    = 1'b0;
    bad_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid_in && rx_dv_in) begin
          if (byte_in == 8'h55) begin
            state_nxt   = PRE;
            pre_cnt_nxt = 4'd1;
          end else begin
            state_nxt = DROP;
            bad_inc   = 1'b1;
          end
        end
      end
      PRE: begin
        if (!rx_dv_in) begin
          state_nxt = IDLE;
          bad_inc   = 1'b1;
        end else if (byte_valid_in) begin
          if (byte_in == 8'h55) begin
            if (pre_cnt != 4'hF) pre_cnt_nxt = pre_cnt + 4'd1;
          end else if (byte_in == 8'hD5 && pre_cnt >= PRE_NEED) begin
            state_nxt   = DATA;
            len_nxt     = 11'd0;
            er_flag_nxt = 1'b0;
          end else begin
            state_nxt = DROP;
            bad_inc   = 1'b1;
          end
        end
      end
      DATA: begin
        // dv low wins over a coincident strobe; that byte is never accepted
        if (!rx_dv_in) begin
          state_nxt = IDLE;
          if (len == 11'd0) begin
            bad_inc = 1'b1;
          end else begin
            tvalid_nxt = 1'b1;
            tlast_nxt  = 1'b1;
            tdata_nxt  = hold;
            tuser_nxt  = (len < LEN_MIN) || er_flag;
            bad_inc    = tuser_nxt;
            good_inc   = !tuser_nxt;
          end
        end else if (byte_valid_in) begin
          if (len == LEN_MAX) begin
            state_nxt  = DROP;
            tvalid_nxt = 1'b1;
            tlast_nxt  = 1'b1;
            tuser_nxt  = 1'b1;
            tdata_nxt  = hold;
            bad_inc    = 1'b1;
          end else begin
            len_nxt     = len + 11'd1;
            hold_nxt    = byte_in;
            er_flag_nxt = er_flag | rx_er_in;
            if (len != 11'd0) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = hold;
            end
          end
        end
      end
      DROP: begin
        if (!rx_dv_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      pre_cnt         <= 4'd0;
      len             <= 11'd0;
      hold            <= 8'h00;
      er_flag         <= 1'b0;
      m_tdata_out     <= 8'h00;
      m_tvalid_out    <= 1'b0;
      m_tlast_out     <= 1'b0;
      m_tuser_out     <= 1'b0;
      frame_count_out <= 16'd0;
      err_count_out   <= 16'd0;
      busy_out        <= 1'b0;
    end else begin
      state        <= state_nxt;
      pre_cnt      <= pre_cnt_nxt;
      len          <= len_nxt;
      hold         <= hold_nxt;
      er_flag      <= er_flag_nxt;
      m_tdata_out  <= tdata_nxt;
      m_tvalid_out <= tvalid_nxt;
      m_tlast_out  <= tlast_nxt;
      m_tuser_out  <= tuser_nxt;
      busy_out     <= (state_nxt != IDLE);
      if (good_inc && frame_count_out != 16'hFFFF)
        frame_count_out <= frame_count_out + 16'd1;
      if (bad_inc && err_count_out != 16'hFFFF)
        err_count_out <= err_count_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// tb/tb_eth_rx_frame_ctrl.sv - self-checking bench for eth_rx_frame_ctrl
// Frames are described abstractly (preamble count, length, error byte) and expected beats derived from that.
module tb_eth_rx_frame_ctrl;
  localparam int MIN_PRE = 7;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, dv = 1'b0, er = 1'b0, bv = 1'b0;
  logic [7:0]  bi = 8'h00;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, busy;
  logic [15:0] fcnt, ecnt;

  eth_rx_frame_ctrl #(.MIN_PRE(MIN_PRE), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk_in(clk), .rst_in(rst), .rx_dv_in(dv), .rx_er_in(er),
    .byte_valid_in(bv), .byte_in(bi),
    .m_tdata_out(tdata), .m_tvalid_out(tvalid), .m_tlast_out(tlast), .m_tuser_out(tuser),
    .frame_count_out(fcnt), .err_count_out(ecnt), .busy_out(busy)
  );

  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] pay[$];
  int exp_frames, exp_errs;
  int passed = 0, total = 0;

  always @(negedge clk) if (tvalid) obs_q.push_back({tuser, tlast, tdata});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; dv = 1'b0; bv = 1'b0; er = 1'b0; bi = 8'h00;
    tick(); tick();
    rst = 1'b1;
    tick();
    obs_q.delete(); exp_q.delete();
    exp_frames = 0; exp_errs = 0;
  endtask

  task automatic strobe(input logic [7:0] b, input logic e, input int gap);
    repeat (gap) tick();
    bv = 1'b1; bi = b; er = e;
    tick();
    bv = 1'b0; er = 1'b0;
  endtask

  // Reference: what a receiver should deliver for one described frame
  task automatic model_frame(input int npre, input int len, input int er_idx);
    int n;
    logic bad;
    if (npre < MIN_PRE || len == 0) begin
      exp_errs++;
    end else begin
      n = (len > MAX_LEN) ? MAX_LEN : len;
      bad = (len > MAX_LEN) || (len < MIN_LEN) || (er_idx >= 0 && er_idx < n);
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == n - 1) ? bad : 1'b0, (i == n - 1), pay[i]});
      if (bad) exp_errs++; else exp_frames++;
    end
  endtask

  task automatic send_frame(input int npre, input int len, input int er_idx,
                            input int gap_max, input bit rnd, input bit end_frame);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(rnd ? 8'($urandom) : 8'(i));
    model_frame(npre, len, er_idx);
    dv = 1'b1;
    for (int p = 0; p < npre; p++) strobe(8'h55, 1'b0, int'($urandom_range(gap_max, 0)));
    strobe(8'hD5, 1'b0, int'($urandom_range(gap_max, 0)));
    for (int i = 0; i < len; i++)
      strobe(pay[i], (i == er_idx), int'($urandom_range(gap_max, 0)));
    if (end_frame) begin
      dv = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; dv = 1'b1; bv = 1'b1; bi = 8'h55;
    tick(); tick();
    total++;
    if ({tdata, tvalid, tlast, tuser, busy} !== 12'h000)
      $display("FAIL reset_outputs got %h required 000", {tdata, tvalid, tlast, tuser, busy});
    else passed++;
    total++;
    if ({fcnt, ecnt} !== 32'h0)
      $display("FAIL reset_counters got %h required 00000000", {fcnt, ecnt});
    else passed++;
    bv = 1'b0; dv = 1'b0;
    do_reset();
  endtask

  task automatic test_good();
    int m;
    do_reset();
    send_frame(7, 64, -1, 0, 1'b0, 1'b1);
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0)
      $display("FAIL good_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, exp_q.size());
    else passed++;
    total++;
    if (fcnt !== 16'(exp_frames) || ecnt !== 16'(exp_errs))
      $display("FAIL good_counts got %0d/%0d required %0d/%0d", fcnt, ecnt, exp_frames, exp_errs);
    else passed++;
  endtask

  task automatic test_runt();
    int m;
    do_reset();
    send_frame(7, 10, -1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0)
      $display("FAIL runt_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, exp_q.size());
    else passed++;
    total++;
    if (fcnt !== 16'd0 || ecnt !== 16'd1)
      $display("FAIL runt_counts got %0d/%0d required 0/1", fcnt, ecnt);
    else passed++;
  endtask

  task automatic test_bad_preamble();
    do_reset();
    send_frame(3, 70, -1, 1, 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1) $display("FAIL badpre_busy_high got %b required 1", busy);
    else passed++;
    dv = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL badpre_busy_low got %b required 0", busy);
    else passed++;
    total++;
    if (obs_q.size() != 0 || ecnt !== 16'd1 || fcnt !== 16'd0)
      $display("FAIL badpre_result got beats=%0d err=%0d frames=%0d required 0/1/0", obs_q.size(), ecnt, fcnt);
    else passed++;
  endtask

  task automatic test_oversize();
    int m;
    do_reset();
    send_frame(7, 1600, -1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != MAX_LEN || m >= 0)
      $display("FAIL oversize_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, MAX_LEN);
    else passed++;
    total++;
    if (ecnt !== 16'd1 || fcnt !== 16'd0)
      $display("FAIL oversize_counts got %0d/%0d required 0/1", fcnt, ecnt);
    else passed++;
  endtask

  task automatic test_err_gaps();
    int m;
    do_reset();
    send_frame(7, 64, 20, 3, 1'b1, 1'b1);
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0)
      $display("FAIL errgap_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, exp_q.size());
    else passed++;
    total++;
    if (ecnt !== 16'd1 || fcnt !== 16'd0)
      $display("FAIL errgap_counts got %0d/%0d required 0/1", fcnt, ecnt);
    else passed++;
  endtask

  task automatic test_strobe_on_fall();
    int m;
    do_reset();
    send_frame(8, 64, -1, 2, 1'b1, 1'b0);
    dv = 1'b0; bv = 1'b1; bi = 8'hA5; er = 1'b1;
    tick();
    bv = 1'b0; er = 1'b0;
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0 || fcnt !== 16'd1)
      $display("FAIL fall_strobe got n=%0d first_bad=%0d frames=%0d required n=%0d frames=1",
               obs_q.size(), m, fcnt, exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    int m;
    int lens[5] = '{63, 64, 1518, 0, 65};
    do_reset();
    foreach (lens[k]) send_frame(7, lens[k], -1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0)
      $display("FAIL b2b_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, exp_q.size());
    else passed++;
    total++;
    if (fcnt !== 16'(exp_frames) || ecnt !== 16'(exp_errs))
      $display("FAIL b2b_counts got %0d/%0d required %0d/%0d", fcnt, ecnt, exp_frames, exp_errs);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(7, 30, -1, 0, 1'b1, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 29; i++) exp_q.push_back({2'b00, pay[i]});
    rst = 1'b0;
    tick();
    rst = 1'b1; dv = 1'b0;
    repeat (3) tick();
    total++;
    if (obs_q.size() != 29 || obs_q != exp_q)
      $display("FAIL rstmid_beats got n=%0d required 29 partial beats without tlast", obs_q.size());
    else passed++;
    total++;
    if (fcnt !== 16'd0 || ecnt !== 16'd0)
      $display("FAIL rstmid_counts got %0d/%0d required 0/0", fcnt, ecnt);
    else passed++;
    send_frame(7, 64, -1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    total++;
    if (fcnt !== 16'd1 || ecnt !== 16'd0)
      $display("FAIL rstmid_next got %0d/%0d required 1/0", fcnt, ecnt);
    else passed++;
  endtask

  task automatic test_random();
    int m, npre, len, eidx;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      npre = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 0)) : int'($urandom_range(12, 7));
      case ($urandom_range(4, 0))
        0: len = 0;
        1: len = int'($urandom_range(MIN_LEN, MIN_LEN - 2));
        default: len = int'($urandom_range(200, 1));
      endcase
      eidx = ($urandom_range(3, 0) == 0 && len > 0) ? int'($urandom_range(len - 1, 0)) : -1;
      send_frame(npre, len, eidx, 3, 1'b1, 1'b1);
      repeat ($urandom_range(2, 0)) tick();
    end
    repeat (3) tick();
    m = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (m < 0 && obs_q[i] !== exp_q[i]) m = i;
    total++;
    if (obs_q.size() != exp_q.size() || m >= 0)
      $display("FAIL random_beats got n=%0d first_bad=%0d required n=%0d", obs_q.size(), m, exp_q.size());
    else passed++;
    total++;
    if (fcnt !== 16'(exp_frames) || ecnt !== 16'(exp_errs))
      $display("FAIL random_counts got %0d/%0d required %0d/%0d", fcnt, ecnt, exp_frames, exp_errs);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_runt();
    test_bad_preamble();
    test_oversize();
    test_err_gaps();
    test_strobe_on_fall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
